// File: rtl/mc_pkg.sv
// Shared types for the multicycle core: FSM states, opcode/funct codes, ALU encoding.
// MC_CORE_BNE_EN (see mc_ctrl) only changes decode; everything here is always present.
package mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_EXEC,
    S_ALUWB, S_BRANCH, S_ADDIEX, S_ADDIWB, S_JUMP, S_HALT
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [2:0] {
    ALU_AND = 3'b000,
    ALU_OR  = 3'b001,
    ALU_ADD = 3'b010,
    ALU_SUB = 3'b110,
    ALU_SLT = 3'b111
  } alu_e;

  function automatic logic funct_ok(input logic [5:0] f);
    return f inside {FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT};
  endfunction

  function automatic alu_e alu_dec(input logic [5:0] f);
    case (f)
      FN_SUB:  return ALU_SUB;
      FN_AND:  return ALU_AND;
      FN_OR:   return ALU_OR;
      FN_SLT:  return ALU_SLT;
      default: return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/mc_ctrl.sv
// Control FSM of the multicycle core; memory request outputs are registered.
// Define MC_CORE_BNE_EN to decode bne (opcode 0x05); otherwise it halts the core.
module mc_ctrl
  import mc_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op_i,
  input  logic [5:0] funct_i,
  input  logic       mem_ack_i,
  output state_e     state_o,
  output logic       mem_req_o,
  output logic       mem_we_o,
  output logic       halted_o
);

  state_e state_q, dec_next;
  logic   req_q, we_q, halted_q;

  always_comb begin
    dec_next = S_HALT;
    case (op_i)
      OP_RTYPE: if (funct_ok(funct_i)) dec_next = S_EXEC;
      OP_LW,
      OP_SW:    dec_next = S_MEMADR;
      OP_BEQ:   dec_next = S_BRANCH;
`ifdef MC_CORE_BNE_EN
      OP_BNE:   dec_next = S_BRANCH;
`else
      OP_BNE:   dec_next = S_HALT;
`endif
      OP_ADDI:  dec_next = S_ADDIEX;
      OP_J:     dec_next = S_JUMP;
      default:  dec_next = S_HALT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= S_FETCH;
      req_q    <= 1'b0;
      we_q     <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      case (state_q)
        // req_q is low only in the first FETCH cycle after reset; any ack
        // still in flight from before reset lands there and is ignored.
        S_FETCH:
          if (!req_q) req_q <= 1'b1;
          else if (mem_ack_i) begin
            req_q   <= 1'b0;
            state_q <= S_DECODE;
          end
        S_DECODE: begin
          state_q  <= dec_next;
          halted_q <= (dec_next == S_HALT);
        end
        S_MEMADR: begin
          req_q <= 1'b1;
          if (op_i == OP_SW) begin
            we_q    <= 1'b1;
            state_q <= S_MEMWR;
          end else begin
            state_q <= S_MEMRD;
          end
        end
        S_MEMRD:
          if (mem_ack_i) begin
            req_q   <= 1'b0;
            state_q <= S_MEMWB;
          end
        S_MEMWR:
          if (mem_ack_i) begin
            we_q    <= 1'b0;
            state_q <= S_FETCH;
          end
        S_EXEC:   state_q <= S_ALUWB;
        S_ADDIEX: state_q <= S_ADDIWB;
        S_MEMWB, S_ALUWB, S_ADDIWB, S_BRANCH, S_JUMP: begin
          req_q   <= 1'b1;
          state_q <= S_FETCH;
        end
        default: begin
          req_q    <= 1'b0;
          we_q     <= 1'b0;
          halted_q <= 1'b1;
        end
      endcase
    end
  end

  assign state_o   = state_q;
  assign mem_req_o = req_q;
  assign mem_we_o  = we_q;
  assign halted_o  = halted_q;

endmodule

// File: rtl/mc_core.sv
// Multicycle MIPS-subset core with one shared, variable-latency memory port.
// Datapath, register file and ALU live here; sequencing is in mc_ctrl (MC_CORE_BNE_EN adds bne).
module mc_core
  import mc_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          NREGS    = 32
) (
  input  logic        clk,
  input  logic        reset,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [31:0] pc,
  output logic        halted
);

  localparam int RW = $clog2(NREGS);

  state_e        state;
  logic [31:0]   pc_q, ir_q, a_q, b_q, aluout_q, mdr_q;
  logic [31:0]   rf_q [NREGS];
  logic [5:0]    op, funct;
  logic [RW-1:0] rs, rt, rd, rf_wa;
  logic [31:0]   signimm, alu_b, alu_y, rd_rs, rd_rt, rf_wd;
  alu_e          aluctl;
  logic          ack_ok, taken, rf_we;

  assign ack_ok  = mem_req & mem_ack;
  assign op      = ir_q[31:26];
  assign funct   = ir_q[5:0];
  assign rs      = ir_q[21 +: RW];
  assign rt      = ir_q[16 +: RW];
  assign rd      = ir_q[11 +: RW];
  assign signimm = {{16{ir_q[15]}}, ir_q[15:0]};
  assign rd_rs   = (rs == '0) ? 32'h0 : rf_q[rs];
  assign rd_rt   = (rt == '0) ? 32'h0 : rf_q[rt];
  assign taken   = (op == OP_BNE) ? (a_q != b_q) : (a_q == b_q);

  mc_ctrl u_ctrl (
    .clk       (clk),
    .reset     (reset),
    .op_i      (op),
    .funct_i   (funct),
    .mem_ack_i (ack_ok),
    .state_o   (state),
    .mem_req_o (mem_req),
    .mem_we_o  (mem_we),
    .halted_o  (halted)
  );

  // One ALU: R-type ops in EXEC, address/addi add with the immediate elsewhere.
  always_comb begin
    aluctl = ALU_ADD;
    alu_b  = signimm;
    if (state == S_EXEC) begin
      aluctl = alu_dec(funct);
      alu_b  = b_q;
    end
  end

  always_comb begin
    case (aluctl)
      ALU_AND: alu_y = a_q & alu_b;
      ALU_OR:  alu_y = a_q | alu_b;
      ALU_SUB: alu_y = a_q - alu_b;
      ALU_SLT: alu_y = {31'h0, $signed(a_q) < $signed(alu_b)};
      default: alu_y = a_q + alu_b;
    endcase
  end

  always_comb begin
    rf_we = 1'b0;
    rf_wa = rt;
    rf_wd = aluout_q;
    case (state)
      S_MEMWB: begin
        rf_we = 1'b1;
        rf_wd = mdr_q;
      end
      S_ALUWB: begin
        rf_we = 1'b1;
        rf_wa = rd;
      end
      S_ADDIWB: rf_we = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset && rf_we && rf_wa != '0) rf_q[rf_wa] <= rf_wd;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_q     <= RESET_PC;
      ir_q     <= 32'h0;
      a_q      <= 32'h0;
      b_q      <= 32'h0;
      aluout_q <= 32'h0;
      mdr_q    <= 32'h0;
    end else begin
      case (state)
        S_FETCH:
          if (ack_ok) begin
            ir_q <= mem_rdata;
            pc_q <= pc_q + 32'd4;
          end
        S_DECODE: begin
          a_q      <= rd_rs;
          b_q      <= rd_rt;
          aluout_q <= pc_q + {signimm[29:0], 2'b00};
        end
        S_MEMADR, S_EXEC, S_ADDIEX: aluout_q <= alu_y;
        S_MEMRD:  if (ack_ok) mdr_q <= mem_rdata;
        S_BRANCH: if (taken) pc_q <= aluout_q;
        S_JUMP:   pc_q <= {pc_q[31:28], ir_q[25:0], 2'b00};
        default: ;
      endcase
    end
  end

  assign mem_addr  = (state == S_FETCH) ? pc_q : aluout_q;
  assign mem_wdata = b_q;
  assign pc        = pc_q;

endmodule
